// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converter: FSM state encoding,
// legal lane-ratio limits and a helper for sizing lane index buses.
package stream_pkg;

    // Buffer state: IDLE = nothing held, SEND = wide beat with pending lanes.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Legal range for the number of narrow lanes in one wide beat.
    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 16;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_downsize_if.sv
// Handshake/data bundle around stream_downsize. The slave modport is the
// converter's own view (wide stream in, narrow stream out); the master
// modport is the view of the environment that drives and consumes it.
interface stream_downsize_if #(
    parameter int T_DATA_WIDTH = 32,
    parameter int T_DATA_RATIO = 2
) ();

    logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] s_keep_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o
    );

endinterface

// File: rtl/stream_lane_select.sv
// Lowest-set-bit encoder over the pending-lane mask. Also reports whether
// exactly one lane remains, which drives both the last flag and the
// no-bubble refill of the converter.
module stream_lane_select
    import stream_pkg::*;
#(
    parameter int T_DATA_RATIO = 2
) (
    input  logic [T_DATA_RATIO-1:0]             mask,
    output logic [lane_idx_w(T_DATA_RATIO)-1:0] idx,
    output logic                                one_pending
);

    localparam int IDX_W = lane_idx_w(T_DATA_RATIO);

    // Scan from the top down so the lowest set bit is the final assignment.
    always_comb begin
        // NOTE: default assigned first so no path leaves idx unassigned (no latch).
        idx = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
    end

    // A non-zero mask with a single bit set: clearing its lowest bit leaves zero.
    assign one_pending = (mask != '0) &&
                         ((mask & (mask - T_DATA_RATIO'(1))) == '0);

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: a wide beat of T_DATA_RATIO lanes is
// buffered and emitted one kept lane per narrow beat, lowest lane first.
// T_DATA_RATIO must lie in RATIO_MIN..RATIO_MAX.
// Optional build macro STREAM_DOWNSIZE_ERR_EN adds a sticky err_o flag for
// beats whose keep is all-zero or not contiguous from lane 0.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 32,
    parameter int T_DATA_RATIO = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef STREAM_DOWNSIZE_ERR_EN
    stream_downsize_if.slave  bus,
    output logic              err_o
`else
    stream_downsize_if.slave  bus
`endif
);

    localparam int IDX_W = lane_idx_w(T_DATA_RATIO);

    state_t                  state_q, state_d;
    logic [T_DATA_WIDTH-1:0] beat_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] pend_q;
    logic                    last_q;

    logic [IDX_W-1:0]        lane_idx;
    logic                    one_pending;
    logic                    s_ready;
    logic                    s_fire;
    logic                    m_fire;
    logic                    load;

    stream_lane_select #(
        .T_DATA_RATIO (T_DATA_RATIO)
    ) u_lane_select (
        .mask        (pend_q),
        .idx         (lane_idx),
        .one_pending (one_pending)
    );

    // Refill is allowed only when the final pending lane leaves on this edge.
    assign s_ready = (state_q == IDLE) || (bus.m_ready_i && one_pending);
    assign s_fire  = bus.s_valid_i && s_ready;
    assign m_fire  = (state_q == SEND) && bus.m_ready_i;
    // All-zero keep beats are consumed but never enter the buffer.
    assign load    = s_fire && (bus.s_keep_i != '0);

    assign bus.s_ready_o = s_ready;
    assign bus.m_valid_o = (state_q == SEND);
    assign bus.m_data_o  = (state_q == SEND) ? beat_q[lane_idx] : '0;
    assign bus.m_last_o  = (state_q == SEND) && last_q && one_pending;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a fresh beat keeps us in SEND, draining the last lane idles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (load) state_d = SEND;
            SEND: begin
                if (load)                       state_d = SEND;
                else if (m_fire && one_pending) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer and pending mask: load a new beat, or retire the presented lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the lane buffer is reset too, so m_data_o is defined from reset.
            for (int i = 0; i < T_DATA_RATIO; i++) beat_q[i] <= '0;
            pend_q <= '0;
            last_q <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < T_DATA_RATIO; i++) beat_q[i] <= bus.s_data_i[i];
            pend_q <= bus.s_keep_i;
            last_q <= bus.s_last_i;
        end else if (m_fire) begin
            pend_q <= pend_q & ~(T_DATA_RATIO'(1) << lane_idx);
        end
    end

`ifdef STREAM_DOWNSIZE_ERR_EN
    logic keep_bad;

    // Contiguous-from-lane-0 keep has the form 2^n-1: adding one clears every set bit.
    assign keep_bad = (bus.s_keep_i == '0) ||
                      (((bus.s_keep_i + T_DATA_RATIO'(1)) & bus.s_keep_i) != '0);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_o <= 1'b0;
        else if (s_fire && keep_bad) err_o <= 1'b1;
    end
`endif

endmodule

// File: doc/stream_downsize.md
STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 Parameter T_DATA_WIDTH, default 32, width of one narrow lane in bits.
REQ-002 Parameter T_DATA_RATIO, default 2, number of lanes per wide beat; legal values are 2 to 16.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port s_data_i, input, array of T_DATA_RATIO elements of T_DATA_WIDTH bits: wide beat; lane 0 is the first element in stream order.
REQ-006 Port s_keep_i, input, T_DATA_RATIO bits: bit k set means lane k is valid.
REQ-007 Port s_last_i, input, 1 bit: marks the wide beat as the end of a packet.
REQ-008 Port s_valid_i, input, 1 bit; port s_ready_o, output, 1 bit: upstream handshake.
REQ-009 Port m_data_o, output, T_DATA_WIDTH bits: narrow beat.
REQ-010 Port m_last_o, output, 1 bit: marks the narrow beat as the end of a packet.
REQ-011 Port m_valid_o, output, 1 bit; port m_ready_i, input, 1 bit: downstream handshake.

Function
REQ-012 A transfer SHALL occur on any rising edge where valid and ready are both high; the transfer rule is identical on both sides.
REQ-013 States: IDLE (buffer empty) and SEND (buffer holds a wide beat with at least one pending lane).
REQ-014 In IDLE, s_ready_o SHALL be 1 and m_valid_o SHALL be 0.
REQ-015 When a beat is accepted with non-zero s_keep_i, the block SHALL register s_data_i, s_keep_i and s_last_i and go to SEND.
REQ-016 m_valid_o SHALL rise on the cycle after acceptance; there is no combinational path from s_data_i to m_data_o.
REQ-017 In SEND, m_data_o SHALL present the lowest-index pending lane.
REQ-018 On each downstream transfer in SEND, that lane SHALL be cleared from the pending mask.
REQ-019 m_last_o SHALL be 1 only when the registered last flag is 1 and the presented lane is the highest pending lane.
REQ-020 In SEND, s_ready_o SHALL equal m_ready_i AND (exactly one lane pending).
REQ-021 A wide beat accepted under the REQ-020 condition SHALL replace the buffer on the same edge, with no bubble cycle.
REQ-022 With full keep and constant m_ready_i=1, output throughput SHALL be one narrow beat per cycle.
REQ-023 When the last pending lane transfers and no new beat is accepted on that edge, the block SHALL return to IDLE.
REQ-024 While m_ready_i=0, m_data_o, m_last_o and m_valid_o SHALL hold stable.
REQ-025 Lanes whose keep bit is 0 SHALL be skipped, including lanes between set bits; no narrow beat is emitted for them.
REQ-026 A beat with s_keep_i all-zero SHALL be accepted and discarded without output, and the state SHALL stay IDLE; its s_last_i is dropped.
REQ-027 s_data_i, s_keep_i and s_last_i SHALL be ignored whenever s_valid_i=0.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=1, and pending mask and buffer cleared.
REQ-029 Assertion of rst_n mid-SEND SHALL discard the buffered beat immediately, with no partial output after release.
REQ-030 After reset release, the first rising edge SHALL be able to accept a beat.

Configuration
REQ-031 Macro STREAM_DOWNSIZE_ERR_EN defined: the block SHALL add an output port err_o, 1 bit, reset to 0.
REQ-032 err_o SHALL be set sticky on accepting a beat whose keep is all-zero or non-contiguous from lane 0, and SHALL be cleared only by reset.
REQ-033 Macro undefined: port err_o and its logic SHALL be absent; data-path behaviour SHALL be identical to the macro-defined build.

Structure
REQ-034 Shared package stream_pkg SHALL hold the state enum (IDLE, SEND) and the ratio limit constants.
REQ-035 Sub-module stream_lane_select SHALL be a combinational lowest-set-bit encoder returning the lane index plus a one-pending flag, parameterised by T_DATA_RATIO.

Verification
REQ-036 Reset, then data={0x11,0x22}, keep=2'b11, last=1, m_ready_i=1 -> m_data_o=0x11 with m_last_o=0 on cycle 1, then 0x22 with m_last_o=1 on cycle 2, then m_valid_o=0.
REQ-037 Back-to-back beats {1,2} and {3,4}, keep=11, m_ready_i=1 -> narrow beats 1,2,3,4 on four consecutive cycles, with s_ready_o high on the edge that transfers lane 1.
REQ-038 Partial last beat data={0x5,X}, keep=2'b01, last=1 -> a single beat 0x5 with m_last_o=1.
REQ-039 m_ready_i toggled randomly during SEND -> m_data_o stable while stalled; the output sequence equals the lane-order concatenation of the input; no beat is lost or duplicated.
REQ-040 keep=2'b00 with STREAM_DOWNSIZE_ERR_EN defined -> no output beat and err_o=1 until reset.
REQ-041 rst_n pulsed low while lane 1 is pending -> m_valid_o=0 immediately; the next beat after release is emitted correctly.
